// File: rtl/clcg_stream_decryptor_if.sv
// Ciphertext-in / plaintext-out byte streams of the CLCG decryptor.
interface clcg_stream_decryptor_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] ct_data;
   logic              ct_valid;
   logic              ct_ready;
   logic [DATA_W-1:0] pt_data;
   logic              pt_valid;
   logic              pt_ready;

   modport master (
      output ct_data, ct_valid, pt_ready,
      input  ct_ready, pt_data, pt_valid
   );

   modport slave (
      input  ct_data, ct_valid, pt_ready,
      output ct_ready, pt_data, pt_valid
   );
endinterface

// File: rtl/clcg_stream_decryptor.sv
// Dual-CLCG receive side: seeds the keystream generator, packs Zi bits
// into buffered key words and XORs them onto the ciphertext stream.
module clcg_stream_decryptor #(
   parameter int DATA_W    = 8,
   parameter int KEY_DEPTH = 4,
   localparam int AW = $clog2(KEY_DEPTH),
   localparam int LW = AW + 1,
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sync,
   output logic          ks_start,
   input  logic          ks_bit,
   output logic [LW-1:0] key_level,
   output logic          err_overrun,
   clcg_stream_decryptor_if.slave stream
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEED = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   logic [1:0]        state;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] key_word;
   logic [DATA_W-1:0] mem [KEY_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              run;
   logic              push;
   logic              pop;
   logic              full;
   logic              overrun;
   logic              wr_en;

   assign run      = (state == RUN);
   assign ks_start = (state == SEED);
   assign key_word = {shreg[DATA_W-2:0], ks_bit};
   assign push     = run && (bit_cnt == LAST);
   assign full     = (key_level == LW'(KEY_DEPTH));
   assign pop      = stream.ct_valid && stream.ct_ready;
   assign overrun  = push && full && !pop;
   assign wr_en    = push && !overrun && !sync;

   // Only words already stored count; a same-cycle push shows up next cycle.
   assign stream.ct_ready = run && (key_level != '0)
                         && (!stream.pt_valid || stream.pt_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         err_overrun <= 1'b0;
      end else if (sync) begin
         state       <= SEED;
         err_overrun <= 1'b0;
      end else begin
         unique case (state)
            IDLE: state <= IDLE;
            SEED: state <= RUN;
            RUN: begin
               if (overrun) begin
                  state       <= ERR;
                  err_overrun <= 1'b1;
               end
            end
            default: state <= ERR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (sync) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (run) begin
         shreg   <= key_word;
         bit_cnt <= push ? '0 : bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= key_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         key_level <= '0;
      end else if (sync) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         key_level <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !pop)
            key_level <= key_level + 1'b1;
         else if (pop && !wr_en)
            key_level <= key_level - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stream.pt_valid <= 1'b0;
         stream.pt_data  <= '0;
      end else if (sync) begin
         stream.pt_valid <= 1'b0;
      end else if (pop) begin
         stream.pt_valid <= 1'b1;
         stream.pt_data  <= stream.ct_data ^ mem[rd_ptr];
      end else if (stream.pt_ready) begin
         stream.pt_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_clcg_stream_decryptor.sv
// Directed bench for clcg_stream_decryptor: seeding, key packing,
// XOR datapath, overrun, backpressure, resync and async reset.
module tb_clcg_stream_decryptor;

   logic       clk;
   logic       rst_n;
   logic       sync;
   logic       ks_start;
   logic       ks_bit;
   logic [2:0] key_level;
   logic       err_overrun;

   int n_total;
   int n_pass;

   clcg_stream_decryptor_if #(.DATA_W(8)) bus ();

   clcg_stream_decryptor #(
      .DATA_W(8),
      .KEY_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sync(sync),
      .ks_start(ks_start),
      .ks_bit(ks_bit),
      .key_level(key_level),
      .err_overrun(err_overrun),
      .stream(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Pulse sync from a falling edge; returns one cycle after ks_start drops.
   task automatic do_sync();
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      chk("seed_ks_start_hi", 32'(ks_start), 32'd1);
      chk("seed_level_flush", 32'(key_level), 32'd0);
      chk("seed_pt_flush", 32'(bus.pt_valid), 32'd0);
      chk("seed_err_clear", 32'(err_overrun), 32'd0);
      @(negedge clk);
      chk("seed_ks_start_lo", 32'(ks_start), 32'd0);
   endtask

   task automatic feed(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         ks_bit = b[i];
         @(negedge clk);
      end
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n = 1'b0;
      sync  = 1'b0;
      ks_bit = 1'b0;
      bus.ct_valid = 1'b0;
      bus.ct_data  = 8'h00;
      bus.pt_ready = 1'b1;
      #1;
      chk("rst_ks_start", 32'(ks_start), 32'd0);
      chk("rst_ct_ready", 32'(bus.ct_ready), 32'd0);
      chk("rst_pt_valid", 32'(bus.pt_valid), 32'd0);
      chk("rst_pt_data", 32'(bus.pt_data), 32'd0);
      chk("rst_level", 32'(key_level), 32'd0);
      chk("rst_err", 32'(err_overrun), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // constant-one keystream, then alternating bits
      ks_bit = 1'b1;
      do_sync();
      repeat (7) @(negedge clk);
      chk("t2_level_7bits", 32'(key_level), 32'd0);
      @(negedge clk);
      chk("t2_level_8bits", 32'(key_level), 32'd1);
      chk("t2_ct_ready", 32'(bus.ct_ready), 32'd1);
      bus.ct_data  = 8'h5A;
      bus.ct_valid = 1'b1;
      @(negedge clk);
      bus.ct_valid = 1'b0;
      chk("t2_pt_valid", 32'(bus.pt_valid), 32'd1);
      chk("t2_pt_a5", 32'(bus.pt_data), 32'hA5);
      chk("t2_level_pop", 32'(key_level), 32'd0);
      for (int i = 1; i < 8; i++) begin
         ks_bit = (i % 2 == 0);
         @(negedge clk);
      end
      chk("t2_pt_drained", 32'(bus.pt_valid), 32'd0);
      chk("t2_level_aa", 32'(key_level), 32'd1);
      bus.ct_data  = 8'hFF;
      bus.ct_valid = 1'b1;
      @(negedge clk);
      bus.ct_valid = 1'b0;
      chk("t2_pt_55", 32'(bus.pt_data), 32'h55);

      // backpressure
      do_sync();
      feed(8'h12);
      feed(8'h34);
      feed(8'h56);
      chk("t5_level3", 32'(key_level), 32'd3);
      bus.pt_ready = 1'b0;
      bus.ct_data  = 8'hF0;
      bus.ct_valid = 1'b1;
      @(negedge clk);
      chk("t5_pt_valid", 32'(bus.pt_valid), 32'd1);
      chk("t5_pt_e2", 32'(bus.pt_data), 32'hE2);
      bus.ct_data = 8'h0F;
      repeat (5) begin
         @(negedge clk);
         chk("t5_hold_data", 32'(bus.pt_data), 32'hE2);
         chk("t5_hold_valid", 32'(bus.pt_valid), 32'd1);
         chk("t5_hold_ready", 32'(bus.ct_ready), 32'd0);
      end
      bus.pt_ready = 1'b1;
      @(negedge clk);
      chk("t5_pt_3b", 32'(bus.pt_data), 32'h3B);
      bus.ct_data = 8'hAA;
      @(negedge clk);
      chk("t5_pt_fc", 32'(bus.pt_data), 32'hFC);
      bus.ct_valid = 1'b0;
      @(negedge clk);
      chk("t5_drain", 32'(bus.pt_valid), 32'd0);
      chk("t5_level1", 32'(key_level), 32'd1);

      // resync with pending output and buffered keys
      do_sync();
      feed(8'h11);
      feed(8'h22);
      feed(8'h33);
      feed(8'h44);
      chk("t6_level4", 32'(key_level), 32'd4);
      bus.pt_ready = 1'b0;
      bus.ct_data  = 8'h00;
      bus.ct_valid = 1'b1;
      @(negedge clk);
      bus.ct_valid = 1'b0;
      chk("t6_level3", 32'(key_level), 32'd3);
      chk("t6_pt_11", 32'(bus.pt_data), 32'h11);
      ks_bit = 1'b1;
      do_sync();
      feed(8'h3C);
      chk("t6_level_new", 32'(key_level), 32'd1);
      bus.pt_ready = 1'b1;
      bus.ct_valid = 1'b1;
      @(negedge clk);
      bus.ct_valid = 1'b0;
      chk("t6_pt_3c", 32'(bus.pt_data), 32'h3C);

      // overrun
      ks_bit = 1'b1;
      do_sync();
      repeat (32) @(negedge clk);
      chk("t3_level4", 32'(key_level), 32'd4);
      chk("t3_ready_full", 32'(bus.ct_ready), 32'd1);
      repeat (7) @(negedge clk);
      chk("t3_err_39", 32'(err_overrun), 32'd0);
      @(negedge clk);
      chk("t3_err_40", 32'(err_overrun), 32'd1);
      chk("t3_ready_err", 32'(bus.ct_ready), 32'd0);
      chk("t3_level_err", 32'(key_level), 32'd4);
      do_sync();

      // full FIFO with a pop on the pushing edge
      repeat (39) @(negedge clk);
      bus.ct_data  = 8'h00;
      bus.ct_valid = 1'b1;
      @(negedge clk);
      bus.ct_valid = 1'b0;
      chk("t4_no_err", 32'(err_overrun), 32'd0);
      chk("t4_level4", 32'(key_level), 32'd4);
      chk("t4_pt_ff", 32'(bus.pt_data), 32'hFF);

      // asynchronous reset mid-stream
      do_sync();
      repeat (24) @(negedge clk);
      bus.pt_ready = 1'b0;
      bus.ct_data  = 8'h0F;
      bus.ct_valid = 1'b1;
      @(negedge clk);
      bus.ct_valid = 1'b0;
      chk("t1_level2", 32'(key_level), 32'd2);
      chk("t1_pt_f0", 32'(bus.pt_data), 32'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_ct_ready", 32'(bus.ct_ready), 32'd0);
      chk("t1_pt_valid", 32'(bus.pt_valid), 32'd0);
      chk("t1_pt_data", 32'(bus.pt_data), 32'd0);
      chk("t1_level", 32'(key_level), 32'd0);
      chk("t1_ks_start", 32'(ks_start), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.pt_ready = 1'b1;
      bus.ct_valid = 1'b1;
      repeat (10) @(negedge clk);
      chk("t1_idle_level", 32'(key_level), 32'd0);
      chk("t1_idle_ready", 32'(bus.ct_ready), 32'd0);
      chk("t1_idle_start", 32'(ks_start), 32'd0);
      chk("t1_idle_pt", 32'(bus.pt_valid), 32'd0);
      bus.ct_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
